// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// Definitions
//   Shared types and helpers for the UART link (transmitter and receiver).
//   Contents:
//     CeilLog2   - constant function giving the bit width needed for a counter
//                  range 0..value-1 (never less than 1)
//     tx_state_e - transmitter FSM states; PARITY is only reachable when the
//                  UART_TX_PARITY_EN macro is defined
// -----------------------------------------------------------------------------
package Definitions;

  function automatic int CeilLog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    // A zero-width counter is not legal, so clamp to one bit.
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
//   Bit-period timer shared by the UART transmitter and receiver. A counter
//   runs 0..BIT_CYCLES-1 and wraps; tick is high for the single cycle in which
//   the counter holds its last value, so the consumer advances one bit on the
//   edge where the counter wraps back to 0.
//   Parameters:
//     BIT_CYCLES - clk cycles per bit (FREQUENCY/BAUDRATE), must be >= 2
//   Ports:
//     clk   in  system clock
//     rst   in  asynchronous active-low reset
//     clear in  holds the counter at 0 while high (suppresses tick)
//     tick  out one-cycle pulse, counter wrap
// -----------------------------------------------------------------------------
module baud_tick_gen
  import Definitions::*;
#(
  parameter int BIT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = CeilLog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Derived from the counter register only; clear masks it so the consumer
  // never sees a stale wrap on the cycle it restarts the count.
  assign tick = !clear && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Asynchronous serial transmitter: start bit, WORD_LENGTH data bits LSB
//   first, optional even-parity bit, one stop bit. The line idles high.
//   Build option:
//     UART_TX_PARITY_EN - when defined, one even-parity bit (XOR of the word)
//                         is sent after the data; otherwise no parity bit.
//   Parameters:
//     WORD_LENGTH - data bits per frame
//     FREQUENCY   - clk frequency in Hz
//     BAUDRATE    - line bit rate; FREQUENCY/BAUDRATE must be >= 2
//   Ports:
//     clk      in  system clock
//     rst      in  asynchronous active-low reset (aborts any frame)
//     TX_data  in  word to send, sampled on the accept cycle only
//     transmit in  start request, accepted when busy is low
//     TX_out   out serial line (registered)
//     busy     out high from the accept edge until the frame ends
//     sent     out one-cycle pulse when the stop bit completes
// -----------------------------------------------------------------------------
module uart_tx
  import Definitions::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int FREQUENCY   = 50000000,
  parameter int BAUDRATE    = 9600
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_LENGTH-1:0] TX_data,
  input  logic                   transmit,
  output logic                   TX_out,
  output logic                   busy,
  output logic                   sent
);

  localparam int BIT_CYCLES = FREQUENCY / BAUDRATE;
  localparam int BCNT_W     = CeilLog2(WORD_LENGTH + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_LENGTH - 1);

  tx_state_e              state_q, state_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic [BCNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   sent_q, sent_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic tick;
  logic baud_clear;

  // Holding the timer cleared in IDLE means it starts from 0 on the accept
  // edge, so every bit lasts exactly BIT_CYCLES from there on.
  assign baud_clear = (state_q == IDLE);

  baud_tick_gen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sent_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (transmit) begin
          shift_d   = TX_data;
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          // Parity is captured with the word since the shifter is consumed.
          parity_d  = ^TX_data;
`endif
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          sent_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level and busy are decoded from the *next* state so that they are
  // registered yet change on the same edge as the state itself.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign TX_out = tx_q;
  assign busy   = busy_q;
  assign sent   = sent_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Directed bench for uart_tx at BIT_CYCLES=16, WORD_LENGTH=8. Expected line
//   patterns are written out by hand per word; bit i of each vector is frame
//   bit i (bit 0 = start). Works for both builds of UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int WL   = 8;
  localparam int FREQ = 160;
  localparam int BAUD = 10;
  localparam int BC   = 16;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
  localparam logic [10:0] EXP_A5 = 11'b10101001010;
  localparam logic [10:0] EXP_07 = 11'b11000001110;
  localparam logic [10:0] EXP_3C = 11'b10001111000;
  localparam logic [10:0] EXP_55 = 11'b10010101010;
  localparam logic [10:0] EXP_AA = 11'b10101010100;
`else
  localparam int FB = 10;
  localparam logic [10:0] EXP_A5 = 11'b01101001010;
  localparam logic [10:0] EXP_07 = 11'b01000001110;
  localparam logic [10:0] EXP_3C = 11'b01001111000;
  localparam logic [10:0] EXP_55 = 11'b01010101010;
  localparam logic [10:0] EXP_AA = 11'b01101010100;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          transmit = 1'b0;
  logic [WL-1:0] TX_data = '0;
  logic          TX_out;
  logic          busy;
  logic          sent;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .WORD_LENGTH(WL),
    .FREQUENCY  (FREQ),
    .BAUDRATE   (BAUD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .TX_data (TX_data),
    .transmit(transmit),
    .TX_out  (TX_out),
    .busy    (busy),
    .sent    (sent)
  );

  // Pulse transmit for one edge (E0). Returns at the negedge after E0,
  // which is sample index 0 of the frame.
  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    TX_data  = d;
    transmit = 1'b1;
    @(negedge clk);
    transmit = 1'b0;
  endtask

  // Checks one whole frame starting at sample index 0, one comparison per
  // frame bit (all 16 cycles of it) plus the sent cycle. poke_at >= 0 raises
  // transmit with poke_data at that sample for one edge. chain=1 leaves
  // without the post-sent check so a following frame can start at once.
  task automatic check_frame(input string tag, input logic [10:0] exp_line,
                             input int poke_at, input logic [7:0] poke_data,
                             input bit chain);
    for (int b = 0; b < FB; b++) begin
      int   bad;
      logic l_tx, l_busy, l_sent;
      bad = 0;
      l_tx = 1'b0; l_busy = 1'b0; l_sent = 1'b0;
      for (int c = 0; c < BC; c++) begin
        int k;
        k = b * BC + c;
        if (TX_out !== exp_line[b] || busy !== 1'b1 || sent !== 1'b0) begin
          bad++;
          l_tx = TX_out; l_busy = busy; l_sent = sent;
        end
        if (poke_at >= 0) begin
          if (k == poke_at) begin
            TX_data  = poke_data;
            transmit = 1'b1;
          end else if (k == poke_at + 1) begin
            transmit = 1'b0;
          end
        end
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL %s bit%0d: %0d bad cycles, got tx=%b busy=%b sent=%b, required tx=%b busy=1 sent=0",
                 tag, b, bad, l_tx, l_busy, l_sent, exp_line[b]);
      end
    end
    checks++;
    if (TX_out !== 1'b1 || busy !== 1'b0 || sent !== 1'b1) begin
      failures++;
      $display("FAIL %s end: got tx=%b busy=%b sent=%b, required tx=1 busy=0 sent=1",
               tag, TX_out, busy, sent);
    end
    @(negedge clk);
    if (!chain) begin
      checks++;
      if (sent !== 1'b0 || busy !== 1'b0 || TX_out !== 1'b1) begin
        failures++;
        $display("FAIL %s after: got tx=%b busy=%b sent=%b, required tx=1 busy=0 sent=0",
                 tag, TX_out, busy, sent);
      end
    end
  endtask

  // Line must stay idle (high, not busy, no sent) for n cycles.
  task automatic check_idle(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (TX_out !== 1'b1 || busy !== 1'b0 || sent !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d non-idle cycles, required 0", tag, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (TX_out !== 1'b1 || busy !== 1'b0 || sent !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got tx=%b busy=%b sent=%b, required tx=1 busy=0 sent=0",
               TX_out, busy, sent);
    end
    rst = 1'b1;
    check_idle("reset_idle", 200);
    $display("test_reset done");
  endtask

  task automatic test_single();
    start_frame(8'hA5);
    check_frame("single_A5", EXP_A5, -1, 8'h00, 1'b0);
    $display("test_single 0xA5 done");
  endtask

  task automatic test_parity_word();
    start_frame(8'h07);
    check_frame("word_07", EXP_07, -1, 8'h00, 1'b0);
    $display("test_parity_word 0x07 done");
  endtask

  task automatic test_ignore_busy();
    start_frame(8'h3C);
    check_frame("ignore_3C", EXP_3C, 50, 8'hFF, 1'b0);
    check_idle("ignore_no_second", 40);
    $display("test_ignore_busy 0x3C done");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    TX_data  = 8'h55;
    transmit = 1'b1;
    @(negedge clk);
    TX_data  = 8'hAA;  // latched only at the next accept
    check_frame("b2b_55", EXP_55, -1, 8'h00, 1'b1);
    transmit = 1'b0;
    check_frame("b2b_AA", EXP_AA, -1, 8'h00, 1'b0);
    $display("test_back_to_back 0x55,0xAA done");
  endtask

  task automatic test_mid_reset();
    int bad;
    start_frame(8'hA5);
    repeat (70) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (TX_out !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_now: got tx=%b busy=%b, required tx=1 busy=0", TX_out, busy);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sent !== 1'b0 || TX_out !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_reset_hold: %0d bad cycles, required 0", bad);
    end
    rst = 1'b1;
    check_idle("mid_reset_release", 120);
    start_frame(8'hA5);
    check_frame("post_reset_A5", EXP_A5, -1, 8'h00, 1'b0);
    $display("test_mid_reset done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity_word();
    test_ignore_busy();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter. It accepts a parallel word with a single-cycle request and shifts it onto the line as a standard asynchronous frame: start bit, data LSB first, optional parity, one stop bit. It is the far-end partner of the UART receiver on the same link and shares its frame format and baud derivation. It sits between the user/control logic that produces bytes and the board TX pin.

## Interface
Parameters:
- WORD_LENGTH, 8, data bits per frame
- FREQUENCY, 50000000, clk frequency in Hz
- BAUDRATE, 9600, line bit rate; BIT_CYCLES = FREQUENCY/BAUDRATE (integer division, truncating), must be ≥ 2

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  asynchronous, active-low reset
- TX_data  in  WORD_LENGTH  word to send; sampled only on the accept cycle
- transmit  in  1  start request; accepted when high and busy low at a rising edge
- TX_out  out  1  serial line, registered, idle high
- busy  out  1  high from the accept edge until the frame ends
- sent  out  1  one-cycle pulse at the end of the stop bit

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - TX_out=1, busy=0.
  - On transmit=1, latch TX_data into the shift register, clear the baud counter and bit counter, and go to START.
- START:
  - TX_out=0 for BIT_CYCLES, then go to DATA.
- DATA:
  - TX_out = shift_reg[0].
  - Shift right once every BIT_CYCLES.
  - After WORD_LENGTH bits, go to PARITY (if enabled) or STOP.
- PARITY:
  - TX_out = even parity, the XOR of the latched word, for BIT_CYCLES.
- STOP:
  - TX_out=1 for BIT_CYCLES, then go to IDLE with sent=1 for exactly that cycle.
- transmit while busy=1 is ignored and not queued.
- TX_data changes after the accept edge do not affect the frame in flight.
- Baud counter: width CeilLog2(BIT_CYCLES), counts 0..BIT_CYCLES-1, wraps to 0. Each wrap advances one bit.
- Bit counter: width CeilLog2(WORD_LENGTH+1), cleared at accept.

## Timing
- Reset values (asynchronous, immediate): TX_out=1, busy=0, sent=0, state=IDLE, all counters and the shift register 0.
- Reset mid-frame aborts the frame. The line returns high immediately and sent does not pulse.
- Accept at edge E0: TX_out=0 and busy=1 from E0.
- Bit i of the frame (start = bit 0) is driven from E0+i·BIT_CYCLES to E0+(i+1)·BIT_CYCLES.
- Frame length F = WORD_LENGTH+2, or +3 with parity.
- At edge E0+F·BIT_CYCLES: state=IDLE, busy=0, sent=1 for one cycle.
- Back-to-back frames:
  - transmit high in the sent cycle is accepted at the next edge.
  - The minimum line-idle gap is one clk cycle.
- All outputs are registered, with no combinational path from inputs.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: PARITY state is present and one even-parity bit is inserted after the data.
  - Undefined: the PARITY state and parity logic are removed; the frame is start + data + stop.
- The link receiver must be built with the matching frame format.

## Structure
- Shared package Definitions holds:
  - the CeilLog2 function, already used for counter widths
  - typedef enum tx_state_e {IDLE, START, DATA, PARITY, STOP}
- Sub-module baud_tick_gen (parameter BIT_CYCLES):
  - inputs clk, rst, clear
  - output tick, a one-cycle pulse on counter wrap
  - reusable by the receiver side
- The FSM, shift register and bit counter live in uart_tx.

## Test plan
Bench uses FREQUENCY=160, BAUDRATE=10 (BIT_CYCLES=16), WORD_LENGTH=8.
- Reset idle: hold rst=0, then release → TX_out=1, busy=0, sent=0, with no line activity for 200 cycles.
- Single frame 0xA5, no parity: pulse transmit at E0 → line 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles; sent pulses at E0+160; busy high for cycles E0..E0+159.
- Parity build, 0x07: line is start 0, 1,1,1,0,0,0,0,0, parity 1, stop 1; sent at E0+176.
- Ignore while busy: send 0x3C, then pulse transmit with 0xFF at E0+50 → frame carries 0x3C only, with no second frame.
- Back-to-back: 0x55, then 0xAA with transmit held high through sent → the second start bit begins one cycle after sent; both frames decode correctly.
- Mid-frame reset: assert rst at E0+70 → TX_out=1 and busy=0 immediately, no sent pulse; the next frame after release is correct.
